// File: rtl/framing_pkg.sv
// Frame format shared by the 16-bit framer and deframer: 4-bit sync header
// in bits [15:12] followed by a 12-bit payload, transmitted MSB first.
package framing_pkg;

  localparam int FRAME_W   = 16;
  localparam int SYNC_W    = 4;
  localparam int PAYLOAD_W = 12;
  localparam int POS_W     = $clog2(FRAME_W);

  localparam logic [SYNC_W-1:0] SYNC_WORD_DEF = 4'hB;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  function automatic logic [FRAME_W-1:0] make_frame(
    input logic [SYNC_W-1:0]    hdr,
    input logic [PAYLOAD_W-1:0] payload
  );
    return {hdr, payload};
  endfunction

endpackage

// File: rtl/sync_detector.sv
// Serial-to-parallel shift path, frame position counter and sync comparator
// for the deframer; the top decides when to realign the position counter.
module sync_detector
  import framing_pkg::*;
#(
  parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_WORD_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 pos_clr,
  output logic [PAYLOAD_W-1:0] cand_payload,
  output logic                 boundary,
  output logic                 match
);

  // Only 15 bits need storing; the 16th candidate bit is the live input.
  logic [FRAME_W-2:0] sr_q, sr_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [FRAME_W-1:0] cand;

  always_comb begin
    cand  = {sr_q, bit_in};
    sr_d  = sr_q;
    pos_d = pos_q;
    if (bit_valid) begin
      sr_d  = cand[FRAME_W-2:0];
      pos_d = pos_clr ? '0 : pos_q + 1'b1;
    end
    boundary     = bit_valid && (pos_q == POS_W'(FRAME_W - 1));
    match        = (cand[FRAME_W-1 -: SYNC_W] == SYNC_WORD);
    cand_payload = cand[PAYLOAD_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      pos_q <= '0;
    end else begin
      sr_q  <= sr_d;
      pos_q <= pos_d;
    end
  end

endmodule

// File: rtl/deframer.sv
// Serial deframer: hunts for the sync header, confirms and locks alignment,
// then emits each payload with a one-cycle strobe. Optional sync-miss
// counter on err_cnt is built when DEFRAMER_ERR_CNT_EN is defined.
module deframer
  import framing_pkg::*;
#(
  parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_WORD_DEF,
  parameter int                CONFIRM_N = 3,
  parameter int                LOST_N    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic [PAYLOAD_W-1:0] data_out,
  output logic                 data_valid,
  output logic                 locked
`ifdef DEFRAMER_ERR_CNT_EN
  ,
  output logic [15:0]          err_cnt
`endif
);

  localparam int HIT_W  = $clog2(CONFIRM_N + 1);
  localparam int MISS_W = $clog2(LOST_N + 1);

  function automatic logic [HIT_W-1:0] sat_hit(input logic [HIT_W-1:0] v);
    return (v >= HIT_W'(CONFIRM_N)) ? v : v + 1'b1;
  endfunction

  function automatic logic [MISS_W-1:0] sat_miss(input logic [MISS_W-1:0] v);
    return (v >= MISS_W'(LOST_N)) ? v : v + 1'b1;
  endfunction

  logic [PAYLOAD_W-1:0] cand_payload;
  logic                 boundary;
  logic                 match;
  logic                 pos_clr;

  state_e               state_q, state_d;
  logic [HIT_W-1:0]     hits_q, hits_d, hits_nxt;
  logic [MISS_W-1:0]    misses_q, misses_d, misses_nxt;
  logic                 emit;

  logic [PAYLOAD_W-1:0] data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;
  logic                 locked_q, locked_d;

  sync_detector #(
    .SYNC_WORD (SYNC_WORD)
  ) u_sync_detector (
    .clk          (clk),
    .rst          (rst),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .pos_clr      (pos_clr),
    .cand_payload (cand_payload),
    .boundary     (boundary),
    .match        (match)
  );

  // A fresh detection in SEARCH means the frame just completed, so the next
  // bit starts a new frame.
  assign pos_clr = (state_q == ST_SEARCH) && match;

  always_comb begin
    state_d    = state_q;
    hits_d     = hits_q;
    misses_d   = misses_q;
    emit       = 1'b0;
    hits_nxt   = sat_hit(hits_q);
    misses_nxt = sat_miss(misses_q);
    case (state_q)
      ST_SEARCH: begin
        if (bit_valid && match) begin
          state_d = ST_CONFIRM;
          hits_d  = HIT_W'(1);
        end
      end
      ST_CONFIRM: begin
        if (boundary) begin
          if (match) begin
            hits_d = hits_nxt;
            if (hits_nxt == HIT_W'(CONFIRM_N)) begin
              state_d  = ST_LOCKED;
              misses_d = '0;
              emit     = 1'b1;
            end
          end else begin
            state_d = ST_SEARCH;
            hits_d  = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (boundary) begin
          if (match) begin
            misses_d = '0;
            emit     = 1'b1;
          end else if (misses_nxt >= MISS_W'(LOST_N)) begin
            // Flywheel exhausted: drop lock without emitting this frame.
            state_d  = ST_SEARCH;
            misses_d = '0;
            hits_d   = '0;
          end else begin
            misses_d = misses_nxt;
            emit     = 1'b1;
          end
        end
      end
      default: begin
        state_d  = ST_SEARCH;
        hits_d   = '0;
        misses_d = '0;
      end
    endcase

    data_valid_d = emit;
    data_out_d   = emit ? cand_payload : data_out_q;
    locked_d     = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_SEARCH;
      hits_q       <= '0;
      misses_q     <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      hits_q       <= hits_d;
      misses_q     <= misses_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      locked_q     <= locked_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign locked     = locked_q;

`ifdef DEFRAMER_ERR_CNT_EN
  function automatic logic [15:0] sat_err(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] err_cnt_q, err_cnt_d;
  logic        err_inc;

  always_comb begin
    err_inc   = boundary && !match && (state_q != ST_SEARCH);
    err_cnt_d = err_inc ? sat_err(err_cnt_q) : err_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
